// File: rtl/vpg_pkg.sv
// Shared timing constants, region/state enums and region decode for the VPG path.
// Pure definitions: no latency, no flow control.
package vpg_pkg;

  localparam int COORD_W = 12;
  localparam int MAX_TOT = 4096;

  localparam int H_SYNC_1080 = 44;
  localparam int H_BP_1080   = 148;
  localparam int H_ACT_1080  = 1920;
  localparam int H_FP_1080   = 88;
  localparam int V_SYNC_1080 = 5;
  localparam int V_BP_1080   = 36;
  localparam int V_ACT_1080  = 1080;
  localparam int V_FP_1080   = 4;

  typedef enum logic [1:0] {
    RGN_SYNC,
    RGN_BP,
    RGN_ACT,
    RGN_FP
  } region_e;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  function automatic region_e region_of(input int pos, input int sync, input int bp,
                                        input int act);
    if (pos < sync) return RGN_SYNC;
    else if (pos < sync + bp) return RGN_BP;
    else if (pos < sync + bp + act) return RGN_ACT;
    else return RGN_FP;
  endfunction

endpackage

// File: rtl/vpg_axis_counter.sv
// One raster axis: wrapping position counter plus sync/active region flags.
// Flags are combinational from the registered count; no backpressure, advances on i_inc.
module vpg_axis_counter
  import vpg_pkg::*;
#(
  parameter int SYNC = 2,
  parameter int BP   = 2,
  parameter int ACT  = 8,
  parameter int FP   = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_inc,
  input  logic               i_clr,
  output logic [COORD_W-1:0] o_cnt,
  output logic               o_wrap,
  output logic               o_sync,
  output logic               o_act
);

  localparam int                 TOT  = SYNC + BP + ACT + FP;
  localparam logic [COORD_W-1:0] LAST = COORD_W'(TOT - 1);

  logic [COORD_W-1:0] r_cnt;
  logic               w_last;
  region_e            w_rgn;

  assign w_last = (r_cnt == LAST);
  assign w_rgn  = region_of(int'(r_cnt), SYNC, BP, ACT);

  // Clear wins over increment so an abort always lands on position 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_wrap = i_inc && w_last;
  assign o_sync = (w_rgn == RGN_SYNC);
  assign o_act  = (w_rgn == RGN_ACT);

endmodule

// File: rtl/vpg_timing_gen.sv
// Raster timing generator: IDLE/RUN FSM, H/V axis counters, registered sync/DE/coords.
// One output register stage (outputs lag counters by 1 clock); no backpressure, free-running in RUN.
module vpg_timing_gen
  import vpg_pkg::*;
#(
  parameter int H_SYNC = H_SYNC_1080,
  parameter int H_BP   = H_BP_1080,
  parameter int H_ACT  = H_ACT_1080,
  parameter int H_FP   = H_FP_1080,
  parameter int V_SYNC = V_SYNC_1080,
  parameter int V_BP   = V_BP_1080,
  parameter int V_ACT  = V_ACT_1080,
  parameter int V_FP   = V_FP_1080,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               run,
  output logic [COORD_W-1:0] h_count,
  output logic [COORD_W-1:0] v_count,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic               frame_start
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;

  if (H_TOT > MAX_TOT || V_TOT > MAX_TOT) begin : g_bad_timing
    $error("vpg_timing_gen: raster totals exceed 12-bit counter range");
  end

  state_e             r_state;
  state_e             w_state_nxt;
  logic               w_running;
  logic               w_clr;
  logic [COORD_W-1:0] w_hc;
  logic [COORD_W-1:0] w_vc;
  logic               w_h_wrap;
  logic               w_unused_v_wrap;
  logic               w_h_sync;
  logic               w_v_sync;
  logic               w_h_act;
  logic               w_v_act;
  logic               w_de;
  logic [COORD_W-1:0] w_h_off;
  logic [COORD_W-1:0] w_v_off;

  logic               r_hs;
  logic               r_vs;
  logic               r_de;
  logic               r_fs;
  logic [COORD_W-1:0] r_h_count;
  logic [COORD_W-1:0] r_v_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (run)  w_state_nxt = ST_RUN;
      ST_RUN:  if (!run) w_state_nxt = ST_IDLE;
      default:           w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_running = (r_state == ST_RUN);
  // Counters sit at 0 for every IDLE cycle, so re-entry always starts at the origin.
  assign w_clr     = (w_state_nxt == ST_IDLE);

  vpg_axis_counter #(.SYNC(H_SYNC), .BP(H_BP), .ACT(H_ACT), .FP(H_FP)) u_h_axis (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (w_running),
    .i_clr   (w_clr),
    .o_cnt   (w_hc),
    .o_wrap  (w_h_wrap),
    .o_sync  (w_h_sync),
    .o_act   (w_h_act)
  );

  vpg_axis_counter #(.SYNC(V_SYNC), .BP(V_BP), .ACT(V_ACT), .FP(V_FP)) u_v_axis (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (w_h_wrap),
    .i_clr   (w_clr),
    .o_cnt   (w_vc),
    .o_wrap  (w_unused_v_wrap),
    .o_sync  (w_v_sync),
    .o_act   (w_v_act)
  );

  assign w_de    = w_running && w_h_act && w_v_act;
  assign w_h_off = w_hc - COORD_W'(H_SYNC + H_BP);
  assign w_v_off = w_vc - COORD_W'(V_SYNC + V_BP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hs      <= ~HS_POL;
      r_vs      <= ~VS_POL;
      r_de      <= 1'b0;
      r_fs      <= 1'b0;
      r_h_count <= '0;
      r_v_count <= '0;
    end else begin
      r_hs      <= (w_running && w_h_sync) ? HS_POL : ~HS_POL;
      r_vs      <= (w_running && w_v_sync) ? VS_POL : ~VS_POL;
      r_de      <= w_de;
      r_fs      <= w_running && (w_hc == '0) && (w_vc == '0);
      r_h_count <= w_de ? w_h_off : '0;
      r_v_count <= w_de ? w_v_off : '0;
    end
  end

  assign hs          = r_hs;
  assign vs          = r_vs;
  assign de          = r_de;
  assign frame_start = r_fs;
  assign h_count     = r_h_count;
  assign v_count     = r_v_count;

endmodule

// File: tb/tb_vpg_timing_gen.sv
// Directed bench for vpg_timing_gen on a 14x7 raster, with a positive- and a negative-polarity DUT.
// Expected raster values come from hand-derived region bounds indexed by position since frame_start.
module tb_vpg_timing_gen;

  localparam int HT = 14;
  localparam int FT = 98;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic [11:0] h_count, v_count, h_count_n, v_count_n;
  logic        hs, vs, de, frame_start;
  logic        hs_n, vs_n, de_n, frame_start_n;

  int n_vec = 0;
  int n_err = 0;
  int p = 0;
  int de_cnt = 0;
  int seen[32];
  int since_fs = -1;
  bit first_de_done = 1'b1;

  always #5 clk = ~clk;

  vpg_timing_gen #(
    .H_SYNC(2), .H_BP(2), .H_ACT(8), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_ACT(4), .V_FP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .run(run),
    .h_count(h_count), .v_count(v_count),
    .hs(hs), .vs(vs), .de(de), .frame_start(frame_start)
  );

  vpg_timing_gen #(
    .H_SYNC(2), .H_BP(2), .H_ACT(8), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_ACT(4), .V_FP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_dut_neg (
    .clk(clk), .reset_n(reset_n), .run(run),
    .h_count(h_count_n), .v_count(v_count_n),
    .hs(hs_n), .vs(vs_n), .de(de_n), .frame_start(frame_start_n)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".hs"}, int'(hs), 0);
    chk({tag, ".vs"}, int'(vs), 0);
    chk({tag, ".de"}, int'(de), 0);
    chk({tag, ".h_count"}, int'(h_count), 0);
    chk({tag, ".v_count"}, int'(v_count), 0);
    chk({tag, ".frame_start"}, int'(frame_start), 0);
    chk({tag, ".hs_neg"}, int'(hs_n), 1);
    chk({tag, ".vs_neg"}, int'(vs_n), 1);
    chk({tag, ".de_neg"}, int'(de_n), 0);
    chk({tag, ".fs_neg"}, int'(frame_start_n), 0);
  endtask

  // Each call checks one output cycle per clock, p being the raster position that cycle shows.
  task automatic scan(input int n);
    int hc, vc, act, once;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hc  = p % HT;
      vc  = p / HT;
      act = (hc >= 4 && hc < 12 && vc >= 2 && vc < 6) ? 1 : 0;
      if (p == 0) begin
        de_cnt = 0;
        for (int j = 0; j < 32; j++) seen[j] = 0;
      end
      chk("hs", int'(hs), (hc < 2) ? 1 : 0);
      chk("vs", int'(vs), (vc < 1) ? 1 : 0);
      chk("de", int'(de), act);
      chk("h_count", int'(h_count), (act != 0) ? hc - 4 : 0);
      chk("v_count", int'(v_count), (act != 0) ? vc - 2 : 0);
      chk("frame_start", int'(frame_start), (p == 0) ? 1 : 0);
      chk("hs_neg", int'(hs_n), (hc < 2) ? 0 : 1);
      chk("vs_neg", int'(vs_n), (vc < 1) ? 0 : 1);
      chk("de_neg", int'(de_n), act);
      chk("h_count_neg", int'(h_count_n), (act != 0) ? hc - 4 : 0);
      chk("v_count_neg", int'(v_count_n), (act != 0) ? vc - 2 : 0);
      chk("fs_neg", int'(frame_start_n), (p == 0) ? 1 : 0);

      if (frame_start === 1'b1) begin
        since_fs = 0;
        first_de_done = 1'b0;
      end else if (since_fs >= 0) begin
        since_fs++;
      end
      if (de === 1'b1) begin
        de_cnt++;
        if (h_count < 12'd8 && v_count < 12'd4) seen[int'(v_count) * 8 + int'(h_count)]++;
        if (!first_de_done && since_fs >= 0) begin
          chk("first_de_latency", since_fs, 32);
          first_de_done = 1'b1;
        end
      end
      if (p == FT - 1) begin
        once = 0;
        for (int j = 0; j < 32; j++) if (seen[j] == 1) once++;
        chk("de_per_frame", de_cnt, 32);
        chk("coords_once", once, 32);
      end
      p = (p + 1) % FT;
    end
  endtask

  // Caller has just changed run/reset_n right after edge k: cycles k and k+1 stay idle, k+2 is the origin.
  task automatic expect_start(input string tag);
    @(negedge clk);
    chk({tag, ".fs_k"}, int'(frame_start), 0);
    @(negedge clk);
    chk({tag, ".fs_k1"}, int'(frame_start), 0);
    chk({tag, ".hs_k1"}, int'(hs), 0);
    p = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    run     = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");

    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("idle_after_reset");

    @(posedge clk); #1 run = 1'b1;
    expect_start("run_rise");
    scan(3 * FT);

    // Abort while the counters sit at hc=5, vc=3 (position 47).
    scan(46);
    @(posedge clk); #1 run = 1'b0;
    scan(2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle("abort");
    end

    @(posedge clk); #1 run = 1'b1;
    expect_start("rerun");
    scan(FT);
    scan(48);

    // Asynchronous reset between edges while de is high mid-frame.
    #2 reset_n = 1'b0;
    #1 check_idle("async_reset");
    repeat (2) @(negedge clk);
    check_idle("held_reset");
    @(posedge clk); #1 reset_n = 1'b1;
    expect_start("reset_release");
    scan(FT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
